// File: rtl/serial_rca_ctrl.sv
// Bit-serial adder controller: feeds an external 1-bit full adder LSB first and
// assembles the WIDTH-bit sum, final carry-out and signed overflow.
module serial_rca_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_carry_in,
   input  logic             fa_sum,
   input  logic             fa_carry_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg,  state_next;
   logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
   logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             carry_reg,  carry_next;
   logic             cout_reg,   cout_next;
   logic             ovf_reg,    ovf_next;
   logic [CW-1:0]    cnt_reg,    cnt_next;

   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] result_shift;

   // Operands drain toward bit 0; each new sum bit enters at the MSB so the
   // first (LSB) sum bit ends up in result[0] after WIDTH shifts.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_shift[gi]      = a_sh_reg[gi+1];
         assign b_shift[gi]      = b_sh_reg[gi+1];
         assign result_shift[gi] = result_reg[gi+1];
      end
   endgenerate
   assign a_shift[WIDTH-1]      = 1'b0;
   assign b_shift[WIDTH-1]      = 1'b0;
   assign result_shift[WIDTH-1] = fa_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         a_sh_reg   <= a_sh_next;
         b_sh_reg   <= b_sh_next;
         result_reg <= result_next;
         carry_reg  <= carry_next;
         cout_reg   <= cout_next;
         ovf_reg    <= ovf_next;
         cnt_reg    <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      a_sh_next   = a_sh_reg;
      b_sh_next   = b_sh_reg;
      result_next = result_reg;
      carry_next  = carry_reg;
      cout_next   = cout_reg;
      ovf_next    = ovf_reg;
      cnt_next    = cnt_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next  = RUN;
               a_sh_next   = op_a;
               b_sh_next   = op_b;
               carry_next  = cin;
               cnt_next    = '0;
               result_next = '0;
               cout_next   = 1'b0;
               ovf_next    = 1'b0;
            end
         end
         RUN: begin
            a_sh_next   = a_shift;
            b_sh_next   = b_shift;
            result_next = result_shift;
            carry_next  = fa_carry_out;
            if (cnt_reg == LAST_BIT) begin
               // carry_reg here is the carry into the MSB
               state_next = DONE;
               cout_next  = fa_carry_out;
               ovf_next   = carry_reg ^ fa_carry_out;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy        = (state_reg == RUN);
   assign done        = (state_reg == DONE);
   assign result      = result_reg;
   assign cout        = cout_reg;
   assign ovf         = ovf_reg;
   assign fa_a        = busy & a_sh_reg[0];
   assign fa_b        = busy & b_sh_reg[0];
   assign fa_carry_in = busy & carry_reg;

endmodule

// File: tb/tb_serial_rca_ctrl.sv
// Directed bench for serial_rca_ctrl at WIDTH=8 with a behavioural full adder
// closing the loop between fa_* outputs and fa_sum/fa_carry_out.
module tb_serial_rca_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       cout;
   logic       ovf;
   logic       fa_a;
   logic       fa_b;
   logic       fa_carry_in;
   logic       fa_sum;
   logic       fa_carry_out;

   int checks   = 0;
   int failures = 0;

   serial_rca_ctrl #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op_a         (op_a),
      .op_b         (op_b),
      .cin          (cin),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .cout         (cout),
      .ovf          (ovf),
      .fa_a         (fa_a),
      .fa_b         (fa_b),
      .fa_carry_in  (fa_carry_in),
      .fa_sum       (fa_sum),
      .fa_carry_out (fa_carry_out)
   );

   assign fa_sum       = fa_a ^ fa_b ^ fa_carry_in;
   assign fa_carry_out = (fa_a & fa_b) | (fa_carry_in & (fa_a ^ fa_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one operation and follows it to its done pulse (bounded).
   // glitch_k >= 0 re-pulses start with op_a=0x11 in that RUN cycle.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int glitch_k,
                        output logic [7:0] res, output logic co, output logic ov,
                        output int lat, output int busy_cnt,
                        output logic [7:0] cseq, output logic overlap);
      res = '0; co = 1'b0; ov = 1'b0; lat = -1; busy_cnt = 0; cseq = '0; overlap = 1'b0;
      @(negedge clk);
      op_a = a; op_b = b; cin = c; start = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == glitch_k) begin
            start = 1'b1;
            op_a  = 8'h11;
         end
         if (k == glitch_k + 1) start = 1'b0;
         if (busy && done) overlap = 1'b1;
         if (busy) begin
            busy_cnt++;
            if (k < 8) cseq[k] = fa_carry_in;
         end
         if (done) begin
            lat = k;
            res = result;
            co  = cout;
            ov  = ovf;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, cout, ovf, fa_a, fa_b, fa_carry_in} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b result=%h cout=%b ovf=%b fa=%b%b%b want all 0",
                  busy, done, result, cout, ovf, fa_a, fa_b, fa_carry_in);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
      end
      $display("reset: busy=%b done=%b result=%h", busy, done, result);
   endtask

   task automatic test_basic();
      logic [7:0] r; logic co, ov, ovl; int lat, bc; logic [7:0] cs;
      do_op(8'h5A, 8'h33, 1'b0, -1, r, co, ov, lat, bc, cs, ovl);
      $display("op 5A+33+0: result=%h cout=%b ovf=%b lat=%0d", r, co, ov, lat);
      checks++;
      if ({r, co, ov} !== {8'h8D, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL basic_sum got %h/%b/%b want 8d/0/1", r, co, ov);
      end
      checks++;
      if (lat !== 8) begin
         failures++;
         $display("FAIL basic_latency got %0d want 8", lat);
      end
      checks++;
      if (ovl !== 1'b0) begin
         failures++;
         $display("FAIL busy_done_overlap got %b want 0", ovl);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== 8'h8D) begin
         failures++;
         $display("FAIL done_pulse_width got done=%b result=%h want 0 8d", done, result);
      end
   endtask

   task automatic test_carry_chain();
      logic [7:0] r; logic co, ov, ovl; int lat, bc; logic [7:0] cs;
      do_op(8'hFF, 8'h01, 1'b0, -1, r, co, ov, lat, bc, cs, ovl);
      $display("op FF+01+0: result=%h cout=%b ovf=%b carry_seq=%b", r, co, ov, cs);
      checks++;
      if ({r, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL carry_sum got %h/%b/%b want 00/1/0", r, co, ov);
      end
      checks++;
      if (cs !== 8'b1111_1110) begin
         failures++;
         $display("FAIL carry_in_sequence got %b want 11111110", cs);
      end
   endtask

   task automatic test_cin();
      logic [7:0] r; logic co, ov, ovl; int lat, bc; logic [7:0] cs;
      do_op(8'h00, 8'h00, 1'b1, -1, r, co, ov, lat, bc, cs, ovl);
      $display("op 00+00+1: result=%h cout=%b ovf=%b", r, co, ov);
      checks++;
      if ({r, co, ov} !== {8'h01, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL cin_only got %h/%b/%b want 01/0/0", r, co, ov);
      end
      do_op(8'h7F, 8'h00, 1'b1, -1, r, co, ov, lat, bc, cs, ovl);
      $display("op 7F+00+1: result=%h cout=%b ovf=%b", r, co, ov);
      checks++;
      if ({r, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL cin_overflow got %h/%b/%b want 80/0/1", r, co, ov);
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] r; logic co, ov, ovl; int lat, bc; logic [7:0] cs;
      do_op(8'h5A, 8'h33, 1'b0, 3, r, co, ov, lat, bc, cs, ovl);
      $display("op 5A+33+0 with start at RUN 3: result=%h busy_cycles=%0d lat=%0d", r, bc, lat);
      checks++;
      if ({r, co, ov} !== {8'h8D, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL ignore_start_sum got %h/%b/%b want 8d/0/1", r, co, ov);
      end
      checks++;
      if (bc !== 8 || lat !== 8) begin
         failures++;
         $display("FAIL ignore_start_busy got busy=%0d lat=%0d want 8 8", bc, lat);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result !== 8'h8D) begin
         failures++;
         $display("FAIL ignore_start_not_queued got busy=%b result=%h want 0 8d", busy, result);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] r; logic co, ov, ovl; int lat, bc; logic [7:0] cs;
      logic seen_done;
      seen_done = 1'b0;
      @(negedge clk);
      op_a = 8'h5A; op_b = 8'h33; cin = 1'b0; start = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      $display("abort at RUN 4: busy=%b done=%b result=%h", busy, done, result);
      checks++;
      if ({busy, done, result, cout, ovf, fa_a, fa_b, fa_carry_in} !== 15'd0) begin
         failures++;
         $display("FAIL abort_outputs got busy=%b done=%b result=%h cout=%b ovf=%b fa=%b%b%b want all 0",
                  busy, done, result, cout, ovf, fa_a, fa_b, fa_carry_in);
      end
      repeat (2) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done got activity=%b want 0", seen_done);
      end
      do_op(8'h12, 8'h34, 1'b1, -1, r, co, ov, lat, bc, cs, ovl);
      $display("op 12+34+1 after abort: result=%h cout=%b ovf=%b lat=%0d", r, co, ov, lat);
      checks++;
      if ({r, co, ov} !== {8'h47, 1'b0, 1'b0} || lat !== 8) begin
         failures++;
         $display("FAIL abort_recovery got %h/%b/%b lat=%0d want 47/0/0 lat=8", r, co, ov, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ea, eb; logic ec;
      logic [8:0] exp_sum;
      logic       exp_ovf;
      int n_done, cyc, last_done;
      n_done = 0; last_done = -1;
      @(negedge clk);
      ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
      op_a = ea; op_b = eb; cin = ec; start = 1'b1;
      for (cyc = 0; cyc < 100 && n_done < 5; cyc++) begin
         @(negedge clk);
         if (done) begin
            exp_sum = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
            exp_ovf = (ea[7] == eb[7]) && (exp_sum[7] != ea[7]);
            $display("b2b %0d: %h+%h+%b result=%h cout=%b ovf=%b cycle=%0d",
                     n_done, ea, eb, ec, result, cout, ovf, cyc);
            checks++;
            if ({cout, result, ovf} !== {exp_sum, exp_ovf}) begin
               failures++;
               $display("FAIL b2b_sum got %b/%h/%b want %b/%h/%b",
                        cout, result, ovf, exp_sum[8], exp_sum[7:0], exp_ovf);
            end
            if (last_done >= 0) begin
               checks++;
               if (cyc - last_done !== 10) begin
                  failures++;
                  $display("FAIL b2b_spacing got %0d want 10", cyc - last_done);
               end
            end
            last_done = cyc;
            n_done++;
            ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
            op_a = ea; op_b = eb; cin = ec;
         end else if (busy) begin
            op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
         end
      end
      start = 1'b0;
      checks++;
      if (n_done !== 5) begin
         failures++;
         $display("FAIL b2b_count got %0d want 5", n_done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_chain();
      test_cin();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
